// File: rtl/ulpi_csr_pkg.sv
// Shared constants and types for the ULPI CSR AXI4-Lite responder.
// AXI response codes, ULPI register port widths and the responder FSM states.
package ulpi_csr_pkg;

    // AXI4-Lite response codes used by this block
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // ULPI register port geometry
    localparam int ULPI_REG_AW = 6;
    localparam int ULPI_REG_DW = 8;

    // Responder FSM: one AXI transaction in flight at a time
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        WR_RESP,
        RD_RESP
    } csr_state_e;

endpackage

// File: rtl/ulpi_csr_axil_slave.sv
// AXI4-Lite responder that turns each CSR access into a single ULPI PHY
// register access on a req/ack port and returns the result as a B or R beat.
// Optional feature macro: ULPI_CSR_TIMEOUT_EN -- when defined, an outstanding
// reg_req is abandoned after TIMEOUT_CYCLES cycles and answered with SLVERR.
module ulpi_csr_axil_slave
    import ulpi_csr_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,

    input  logic [31:0]             s_axil_wdata,
    input  logic [3:0]              s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,

    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,

    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,

    output logic [31:0]             s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,

    output logic                    reg_req,
    output logic                    reg_we,
    output logic [ULPI_REG_AW-1:0]  reg_addr,
    output logic [ULPI_REG_DW-1:0]  reg_wdata,
    input  logic                    reg_ack,
    input  logic [ULPI_REG_DW-1:0]  reg_rdata
);

    csr_state_e             state_reg;
    logic                   awready_reg;
    logic                   wready_reg;
    logic                   arready_reg;
    logic                   bvalid_reg;
    logic [1:0]             bresp_reg;
    logic                   rvalid_reg;
    logic [1:0]             rresp_reg;
    logic [31:0]            rdata_reg;
    logic                   reg_req_reg;
    logic                   reg_we_reg;
    logic [ULPI_REG_AW-1:0] reg_addr_reg;
    logic [ULPI_REG_DW-1:0] reg_wdata_reg;
    logic                   last_wr_reg;    // 1 = last channel served was write

    logic wr_cand;
    logic rd_cand;
    logic aw_hi_err;
    logic ar_hi_err;
    logic tmo_hit;

    assign wr_cand = s_axil_awvalid & s_axil_wvalid;
    assign rd_cand = s_axil_arvalid;

    // Only the low 256 bytes map onto ULPI registers; anything above is an error
    generate
        if (ADDR_WIDTH > 8) begin : g_hi_decode
            assign aw_hi_err = |s_axil_awaddr[ADDR_WIDTH-1:8];
            assign ar_hi_err = |s_axil_araddr[ADDR_WIDTH-1:8];
        end else begin : g_no_hi_decode
            assign aw_hi_err = 1'b0;
            assign ar_hi_err = 1'b0;
        end
    endgenerate

`ifdef ULPI_CSR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_reg;

    // Count cycles of an outstanding request; cleared whenever no request is up
    always_ff @(posedge aclk) begin
        if (!aresetn || !reg_req_reg) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    // Fires in the last allowed request cycle; an ack in that same cycle still wins
    assign tmo_hit = reg_req_reg && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Protection bits, upper strobes/data and byte offset carry no meaning here
    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb[3:1],
                             s_axil_wdata[31:8], s_axil_awaddr[1:0],
                             s_axil_araddr[1:0], (TIMEOUT_CYCLES > 0)};

    // Arbitration, ULPI request sequencing and response hold in one FSM
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg     <= IDLE;
            awready_reg   <= 1'b0;
            wready_reg    <= 1'b0;
            arready_reg   <= 1'b0;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= OKAY;
            rvalid_reg    <= 1'b0;
            rresp_reg     <= OKAY;
            rdata_reg     <= '0;
            reg_req_reg   <= 1'b0;
            reg_we_reg    <= 1'b0;
            reg_addr_reg  <= '0;
            reg_wdata_reg <= '0;
            last_wr_reg   <= 1'b0;
        end else begin
            // Ready strobes are single-cycle pulses
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            arready_reg <= 1'b0;

            unique case (state_reg)
                IDLE: begin
                    if (awready_reg) begin
                        // AW and W complete together this cycle (valids are held by the master)
                        reg_we_reg    <= 1'b1;
                        reg_addr_reg  <= s_axil_awaddr[7:2];
                        reg_wdata_reg <= s_axil_wdata[ULPI_REG_DW-1:0];
                        if (aw_hi_err) begin
                            bresp_reg  <= SLVERR;
                            bvalid_reg <= 1'b1;
                            state_reg  <= WR_RESP;
                        end else if (!s_axil_wstrb[0]) begin
                            bresp_reg  <= OKAY;
                            bvalid_reg <= 1'b1;
                            state_reg  <= WR_RESP;
                        end else begin
                            reg_req_reg <= 1'b1;
                            state_reg   <= WR_REQ;
                        end
                    end else if (arready_reg) begin
                        reg_we_reg   <= 1'b0;
                        reg_addr_reg <= s_axil_araddr[7:2];
                        if (ar_hi_err) begin
                            rresp_reg  <= SLVERR;
                            rdata_reg  <= '0;
                            rvalid_reg <= 1'b1;
                            state_reg  <= RD_RESP;
                        end else begin
                            reg_req_reg <= 1'b1;
                            state_reg   <= RD_REQ;
                        end
                    end else if (wr_cand && (!rd_cand || !last_wr_reg)) begin
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                        last_wr_reg <= 1'b1;
                    end else if (rd_cand) begin
                        arready_reg <= 1'b1;
                        last_wr_reg <= 1'b0;
                    end
                end

                WR_REQ: begin
                    if (reg_ack) begin
                        reg_req_reg <= 1'b0;
                        bresp_reg   <= OKAY;
                        bvalid_reg  <= 1'b1;
                        state_reg   <= WR_RESP;
                    end else if (tmo_hit) begin
                        reg_req_reg <= 1'b0;
                        bresp_reg   <= SLVERR;
                        bvalid_reg  <= 1'b1;
                        state_reg   <= WR_RESP;
                    end
                end

                RD_REQ: begin
                    if (reg_ack) begin
                        reg_req_reg <= 1'b0;
                        rdata_reg   <= {{(32 - ULPI_REG_DW){1'b0}}, reg_rdata};
                        rresp_reg   <= OKAY;
                        rvalid_reg  <= 1'b1;
                        state_reg   <= RD_RESP;
                    end else if (tmo_hit) begin
                        reg_req_reg <= 1'b0;
                        rdata_reg   <= '0;
                        rresp_reg   <= SLVERR;
                        rvalid_reg  <= 1'b1;
                        state_reg   <= RD_RESP;
                    end
                end

                WR_RESP: begin
                    if (s_axil_bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end

                RD_RESP: begin
                    if (s_axil_rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign s_axil_awready = awready_reg;
    assign s_axil_wready  = wready_reg;
    assign s_axil_arready = arready_reg;
    assign s_axil_bvalid  = bvalid_reg;
    assign s_axil_bresp   = bresp_reg;
    assign s_axil_rvalid  = rvalid_reg;
    assign s_axil_rresp   = rresp_reg;
    assign s_axil_rdata   = rdata_reg;
    assign reg_req        = reg_req_reg;
    assign reg_we         = reg_we_reg;
    assign reg_addr       = reg_addr_reg;
    assign reg_wdata      = reg_wdata_reg;

endmodule

// File: tb/tb_ulpi_csr_axil_slave.sv
// Self-checking bench for ulpi_csr_axil_slave: directed cases from the plan,
// then randomized traffic, all checked cycle by cycle against a
// transaction-level model of the AXI-Lite / ULPI behaviour.
`timescale 1ns/1ps
module tb_ulpi_csr_axil_slave;

    localparam int AW    = 32;
    localparam int TMO   = 16;
    localparam int LIMIT = 200;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] s_axil_awaddr;
    logic [2:0]    s_axil_awprot;
    logic          s_axil_awvalid;
    logic          s_axil_awready;
    logic [31:0]   s_axil_wdata;
    logic [3:0]    s_axil_wstrb;
    logic          s_axil_wvalid;
    logic          s_axil_wready;
    logic [1:0]    s_axil_bresp;
    logic          s_axil_bvalid;
    logic          s_axil_bready;
    logic [AW-1:0] s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [31:0]   s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;
    logic          reg_req;
    logic          reg_we;
    logic [5:0]    reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_ack;
    logic [7:0]    reg_rdata;

    ulpi_csr_axil_slave #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .reg_req        (reg_req),
        .reg_we         (reg_we),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_ack        (reg_ack),
        .reg_rdata      (reg_rdata)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- ULPI controller responder ----------------
    int  fixed_delay = -1;   // -1: random ack delay
    int  fixed_rdata = -1;   // -1: random read data
    bit  ack_never   = 1'b0;
    bit  stale_en    = 1'b0;
    bit  force_stale = 1'b0;

    initial begin
        int rcnt;
        int cur_delay;
        rcnt = 0;
        cur_delay = 0;
        reg_ack = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            step();
            reg_ack = 1'b0;
            if (reg_req) begin
                if (rcnt == 0) begin
                    if (ack_never) cur_delay = 100000;
                    else if (fixed_delay >= 0) cur_delay = fixed_delay;
`ifdef ULPI_CSR_TIMEOUT_EN
                    else if ($urandom_range(0, 7) == 0) cur_delay = 20;
`endif
                    else cur_delay = int'($urandom_range(0, 5));
                end
                if (rcnt == cur_delay) begin
                    reg_ack = 1'b1;
                    reg_rdata = (fixed_rdata >= 0) ? 8'(fixed_rdata) : 8'($urandom);
                end
                rcnt++;
            end else begin
                rcnt = 0;
                if (force_stale || (stale_en && $urandom_range(0, 7) == 0)) begin
                    reg_ack = 1'b1;
                    reg_rdata = 8'($urandom);
                end
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          mon_en = 1'b0;
    bit          m_req = 1'b0;
    bit          m_we = 1'b0;
    int          m_addr = 0;
    int          m_wdata = 0;
    int          m_age = 0;
    bit          m_bvalid = 1'b0;
    int          m_bresp = 0;
    bit          m_rvalid = 1'b0;
    int          m_rresp = 0;
    int          m_rdata = 0;
    bit          m_rdata_chk = 1'b0;
    bit          prev_aw = 1'b0;
    bit          prev_ar = 1'b0;
    int          req_cycles = 0;
    logic        obs_we;
    logic [5:0]  obs_addr;
    logic [7:0]  obs_wdata;
    bit          acc_q[$];   // 1 = write accepted, 0 = read accepted

    always @(negedge aclk) begin
        if (mon_en) begin
            chk("reg_req", 32'(reg_req), 32'(m_req));
            if (m_req && reg_req) begin
                chk("reg_we", 32'(reg_we), 32'(m_we));
                chk("reg_addr", 32'(reg_addr), 32'(m_addr));
                if (m_we) chk("reg_wdata", 32'(reg_wdata), 32'(m_wdata));
            end
            chk("bvalid", 32'(s_axil_bvalid), 32'(m_bvalid));
            if (m_bvalid) chk("bresp", 32'(s_axil_bresp), 32'(m_bresp));
            chk("rvalid", 32'(s_axil_rvalid), 32'(m_rvalid));
            if (m_rvalid) chk("rresp", 32'(s_axil_rresp), 32'(m_rresp));
            if (m_rvalid && m_rdata_chk) chk("rdata", s_axil_rdata, 32'(m_rdata));
            if (m_req || m_bvalid || m_rvalid)
                chk("ready_while_busy", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd0);
            chk("aw_w_ready_pair", 32'(s_axil_awready), 32'(s_axil_wready));
            chk("one_channel_ready", 32'(s_axil_awready & s_axil_arready), 32'd0);
            chk("ready_one_cycle", 32'((prev_aw & s_axil_awready) | (prev_ar & s_axil_arready)), 32'd0);

            if (reg_req) begin
                req_cycles++;
                obs_we = reg_we;
                obs_addr = reg_addr;
                obs_wdata = reg_wdata;
            end

            // next-cycle expectations from what the DUT samples at the coming edge
            if (!aresetn) begin
                m_req = 1'b0;
                m_bvalid = 1'b0;
                m_rvalid = 1'b0;
            end else begin
                if (m_bvalid && s_axil_bready) m_bvalid = 1'b0;
                if (m_rvalid && s_axil_rready) m_rvalid = 1'b0;
                if (m_req) begin
                    if (reg_ack) begin
                        m_req = 1'b0;
                        if (m_we) begin
                            m_bvalid = 1'b1;
                            m_bresp = 0;
                        end else begin
                            m_rvalid = 1'b1;
                            m_rresp = 0;
                            m_rdata = int'(reg_rdata);
                            m_rdata_chk = 1'b1;
                        end
                    end
`ifdef ULPI_CSR_TIMEOUT_EN
                    else if (m_age + 1 == TMO) begin
                        m_req = 1'b0;
                        if (m_we) begin
                            m_bvalid = 1'b1;
                            m_bresp = 2;
                        end else begin
                            m_rvalid = 1'b1;
                            m_rresp = 2;
                            m_rdata = 0;
                            m_rdata_chk = 1'b1;
                        end
                    end
`endif
                    else begin
                        m_age++;
                    end
                end
                if (s_axil_awvalid && s_axil_awready && s_axil_wvalid && s_axil_wready) begin
                    acc_q.push_back(1'b1);
                    if ((s_axil_awaddr >> 8) != 0) begin
                        m_bvalid = 1'b1;
                        m_bresp = 2;
                    end else if ((s_axil_wstrb % 2) == 0) begin
                        m_bvalid = 1'b1;
                        m_bresp = 0;
                    end else begin
                        m_req = 1'b1;
                        m_we = 1'b1;
                        m_addr = int'(s_axil_awaddr % 256) / 4;
                        m_wdata = int'(s_axil_wdata % 256);
                        m_age = 0;
                    end
                end
                if (s_axil_arvalid && s_axil_arready) begin
                    acc_q.push_back(1'b0);
                    if ((s_axil_araddr >> 8) != 0) begin
                        m_rvalid = 1'b1;
                        m_rresp = 2;
                        m_rdata_chk = 1'b0;
                    end else begin
                        m_req = 1'b1;
                        m_we = 1'b0;
                        m_addr = int'(s_axil_araddr % 256) / 4;
                        m_age = 0;
                    end
                end
            end
            prev_aw = s_axil_awready;
            prev_ar = s_axil_arready;
        end
    end

    // ---------------- AXI-Lite master tasks ----------------
    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int hold, output logic [1:0] resp, output int lat);
        int n;
        int t0;
        s_axil_awaddr = addr;
        s_axil_wdata = data;
        s_axil_wstrb = strb;
        s_axil_awprot = 3'($urandom);
        s_axil_awvalid = 1'b1;
        s_axil_wvalid = 1'b1;
        n = 0;
        while (!(s_axil_awready && s_axil_wready) && n < LIMIT) begin
            step();
            n++;
        end
        chk("aw_accept_in_time", 32'(n < LIMIT), 32'd1);
        t0 = cyc;
        step();
        s_axil_awvalid = 1'b0;
        s_axil_wvalid = 1'b0;
        s_axil_awaddr = $urandom;
        s_axil_wdata = $urandom;
        s_axil_wstrb = 4'($urandom);
        n = 0;
        while (!s_axil_bvalid && n < LIMIT) begin
            step();
            n++;
        end
        chk("b_resp_in_time", 32'(n < LIMIT), 32'd1);
        lat = cyc - t0;
        resp = s_axil_bresp;
        repeat (hold) step();
        s_axil_bready = 1'b1;
        step();
        s_axil_bready = 1'b0;
    endtask

    task automatic axil_read(input logic [31:0] addr, input int hold,
                             output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        int t0;
        s_axil_araddr = addr;
        s_axil_arprot = 3'($urandom);
        s_axil_arvalid = 1'b1;
        n = 0;
        while (!s_axil_arready && n < LIMIT) begin
            step();
            n++;
        end
        chk("ar_accept_in_time", 32'(n < LIMIT), 32'd1);
        t0 = cyc;
        step();
        s_axil_arvalid = 1'b0;
        s_axil_araddr = $urandom;
        n = 0;
        while (!s_axil_rvalid && n < LIMIT) begin
            step();
            n++;
        end
        chk("r_resp_in_time", 32'(n < LIMIT), 32'd1);
        lat = cyc - t0;
        data = s_axil_rdata;
        resp = s_axil_rresp;
        repeat (hold) step();
        s_axil_rready = 1'b1;
        step();
        s_axil_rready = 1'b0;
    endtask

    logic [1:0]  wr_resp;
    int          wr_lat;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    int          rd_lat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        aresetn = 1'b0;
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0;  s_axil_wstrb = '0;  s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0;
        s_axil_rready = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        step();
        aresetn = 1'b1;

        // reset state
        chk("rst_awready", 32'(s_axil_awready), 32'd0);
        chk("rst_wready", 32'(s_axil_wready), 32'd0);
        chk("rst_arready", 32'(s_axil_arready), 32'd0);
        chk("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
        chk("rst_reg_req", 32'(reg_req), 32'd0);
        chk("rst_bresp_rresp", 32'({s_axil_bresp, s_axil_rresp}), 32'd0);
        chk("rst_rdata", s_axil_rdata, 32'd0);

        // write 0x10 <- 0x55, ack three cycles into the request
        fixed_delay = 3;
        req_cycles = 0;
        axil_write(32'h10, 32'h0000_0055, 4'h1, 0, wr_resp, wr_lat);
        chk("w10_bresp", 32'(wr_resp), 32'd0);
        chk("w10_latency", 32'(wr_lat), 32'd5);
        chk("w10_reg_we", 32'(obs_we), 32'd1);
        chk("w10_reg_addr", 32'(obs_addr), 32'h04);
        chk("w10_reg_wdata", 32'(obs_wdata), 32'h55);
        chk("w10_req_cycles", 32'(req_cycles), 32'd4);

        // read 0x0C, immediate ack with 0x1A (minimum latency)
        fixed_delay = 0;
        fixed_rdata = 8'h1A;
        req_cycles = 0;
        axil_read(32'h0C, 0, rd_data, rd_resp, rd_lat);
        chk("r0c_rdata", rd_data, 32'h0000_001A);
        chk("r0c_rresp", 32'(rd_resp), 32'd0);
        chk("r0c_latency", 32'(rd_lat), 32'd2);
        chk("r0c_reg_we", 32'(obs_we), 32'd0);
        chk("r0c_reg_addr", 32'(obs_addr), 32'h03);
        fixed_rdata = -1;

        // decode error and empty-strobe cases never touch ULPI
        req_cycles = 0;
        axil_write(32'h100, 32'hAB, 4'h1, 0, wr_resp, wr_lat);
        chk("w100_bresp", 32'(wr_resp), 32'd2);
        axil_write(32'h20, 32'hCD, 4'h0, 0, wr_resp, wr_lat);
        chk("wstrb0_bresp", 32'(wr_resp), 32'd0);
        axil_read(32'h0000_0200, 0, rd_data, rd_resp, rd_lat);
        chk("r200_rresp", 32'(rd_resp), 32'd2);
        chk("no_ulpi_access", 32'(req_cycles), 32'd0);

        // contention after reset: write first, then alternate
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        acc_q.delete();
        fixed_delay = -1;
        for (int i = 0; i < 4; i++) begin
            fork
                axil_write(32'(4 * i), 32'($urandom), 4'h1, (i == 1) ? 5 : 0, wr_resp, wr_lat);
                axil_read(32'(4 * i + 64), 0, rd_data, rd_resp, rd_lat);
            join
        end
        chk("rr_count", 32'(acc_q.size()), 32'd8);
        for (int i = 0; i < acc_q.size(); i++)
            chk($sformatf("rr_order_%0d", i), 32'(acc_q[i]), 32'((i % 2) == 0));

        // a lone write makes the next contested slot go to read
        acc_q.delete();
        axil_write(32'h30, 32'h11, 4'h1, 0, wr_resp, wr_lat);
        fork
            axil_write(32'h34, 32'h22, 4'h1, 0, wr_resp, wr_lat);
            axil_read(32'h38, 0, rd_data, rd_resp, rd_lat);
        join
        chk("rr_after_write_len", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() == 3) begin
            chk("rr_after_write_0", 32'(acc_q[0]), 32'd1);
            chk("rr_after_write_1", 32'(acc_q[1]), 32'd0);
            chk("rr_after_write_2", 32'(acc_q[2]), 32'd1);
        end

`ifdef ULPI_CSR_TIMEOUT_EN
        // no ack at all: request abandoned after TMO cycles
        ack_never = 1'b1;
        req_cycles = 0;
        axil_read(32'h08, 0, rd_data, rd_resp, rd_lat);
        chk("tmo_rresp", 32'(rd_resp), 32'd2);
        chk("tmo_rdata", rd_data, 32'd0);
        chk("tmo_req_cycles", 32'(req_cycles), 32'(TMO));
        chk("tmo_latency", 32'(rd_lat), 32'(TMO + 1));
        axil_write(32'h08, 32'h99, 4'h1, 0, wr_resp, wr_lat);
        chk("tmo_bresp", 32'(wr_resp), 32'd2);
        ack_never = 1'b0;
        // ack in the very last allowed cycle still counts
        fixed_delay = TMO - 1;
        fixed_rdata = 8'h3C;
        req_cycles = 0;
        axil_read(32'h04, 0, rd_data, rd_resp, rd_lat);
        chk("tmo_edge_rresp", 32'(rd_resp), 32'd0);
        chk("tmo_edge_rdata", rd_data, 32'h3C);
        chk("tmo_edge_req_cycles", 32'(req_cycles), 32'(TMO));
        fixed_rdata = -1;
`else
        // without a timeout the block simply waits for a slow ack
        fixed_delay = 40;
        axil_write(32'h08, 32'h99, 4'h1, 0, wr_resp, wr_lat);
        chk("slow_ack_bresp", 32'(wr_resp), 32'd0);
        chk("slow_ack_latency", 32'(wr_lat), 32'd42);
`endif

        // reset while a request is outstanding, then a stale ack
        ack_never = 1'b1;
        s_axil_araddr = 32'h14;
        s_axil_arvalid = 1'b1;
        n = 0;
        while (!s_axil_arready && n < LIMIT) begin
            step();
            n++;
        end
        chk("mid_rst_accept_in_time", 32'(n < LIMIT), 32'd1);
        step();
        s_axil_arvalid = 1'b0;
        repeat (3) step();
        chk("mid_rst_req_before", 32'(reg_req), 32'd1);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        chk("mid_rst_req_after", 32'(reg_req), 32'd0);
        ack_never = 1'b0;
        force_stale = 1'b1;
        repeat (3) step();
        force_stale = 1'b0;
        chk("stale_ack_rvalid", 32'(s_axil_rvalid), 32'd0);
        chk("stale_ack_req", 32'(reg_req), 32'd0);
        fixed_delay = 1;
        fixed_rdata = 8'h77;
        axil_read(32'h14, 0, rd_data, rd_resp, rd_lat);
        chk("post_rst_rdata", rd_data, 32'h77);
        chk("post_rst_rresp", 32'(rd_resp), 32'd0);

        // randomized traffic with stray acks
        fixed_delay = -1;
        fixed_rdata = -1;
        stale_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [31:0] a1;
            logic [31:0] a2;
            kind = int'($urandom_range(0, 2));
            a1 = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 255));
            a2 = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if (kind == 0) begin
                axil_write(a1, $urandom, 4'($urandom), int'($urandom_range(0, 3)), wr_resp, wr_lat);
            end else if (kind == 1) begin
                axil_read(a2, int'($urandom_range(0, 3)), rd_data, rd_resp, rd_lat);
            end else begin
                fork
                    axil_write(a1, $urandom, 4'($urandom), int'($urandom_range(0, 3)), wr_resp, wr_lat);
                    axil_read(a2, int'($urandom_range(0, 3)), rd_data, rd_resp, rd_lat);
                join
            end
        end
        stale_en = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
